rece_fetch: RTL and testbench

Downstream drain stage for the receive path. It watches `rece_qune`, fires a one-cycle `send_start` into the receive buffer, and captures the fixed-latency 64-bit `sfp_rd_data` stream. It parses the header word and pushes the payload into an internal FIFO. It presents frames on a back-pressurable stream interface with `m_tlast`, since the buffer read side cannot be stalled.

---
 rtl/rece_fetch.sv | 153 +++++++++++++++
 tb/tb_rece_fetch.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rece_fetch.sv
// Receive-path drain stage: pulls one frame per send_start, drops illegal lengths, and buffers
// payload in a tagged FIFO for a back-pressurable stream. Statistics only with RECE_FETCH_STAT_EN.
module rece_fetch #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned MAX_LEN    = 256
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        rece_qune,
  output logic        send_start,
  input  logic [63:0] sfp_rd_data,
  output logic [63:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic        ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] Depth   = (AW + 1)'(FIFO_DEPTH);
  // Highest fill level that still leaves room for a maximum-length frame.
  localparam logic [AW:0] MaxFill = (AW + 1)'(FIFO_DEPTH - MAX_LEN);

  typedef enum logic [2:0] {StIdle, StStart, StLat, StHdr, StPay, StDrop, StGap} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic [AW:0] wr_ptr_q, rd_ptr_q, fill;
  logic [64:0] mem [FIFO_DEPTH];
  logic [64:0] head;
  logic        wr_en, rd_en, wr_ok, full, hdr_ok;
  logic [15:0] hdr_n;

  assign hdr_n  = sfp_rd_data[15:0];
  assign hdr_ok = (hdr_n != 16'd0) && (32'(hdr_n) <= MAX_LEN);
  assign fill   = wr_ptr_q - rd_ptr_q;
  assign full   = (fill == Depth);

  // One counter serves latency, word count and gap timing; the states never overlap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    send_start = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rece_qune && (fill <= MaxFill)) state_d = StStart;
      end
      StStart: begin
        send_start = 1'b1;
        cnt_d      = 16'(RD_LAT - 1);
        state_d    = (RD_LAT > 1) ? StLat : StHdr;
      end
      StLat: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = StHdr;
      end
      StHdr: begin
        cnt_d = hdr_n;
        if (hdr_ok) begin
          state_d = StPay;
        end else if (hdr_n == 16'd0) begin
          state_d = StGap;
          cnt_d   = 16'd1;
        end else begin
          state_d = StDrop;
        end
      end
      StPay: begin
        wr_en = 1'b1;
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = StGap;
          cnt_d   = 16'd1;
        end
      end
      StDrop: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = StGap;
          cnt_d   = 16'd1;
        end
      end
      StGap: begin
        if (cnt_q == 16'd0) state_d = StIdle;
        else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_tvalid = (fill != '0);
  assign rd_en    = m_tvalid && m_tready;
  // A simultaneous read frees the slot, so a full FIFO still accepts the write.
  assign wr_ok    = wr_en && (!full || rd_en);
  assign head     = mem[rd_ptr_q[AW-1:0]];
  assign m_tdata  = m_tvalid ? head[63:0] : 64'd0;
  assign m_tlast  = m_tvalid && head[64];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= {cnt_q == 16'd1, sfp_rd_data};
  end

`ifdef RECE_FETCH_STAT_EN
  logic [15:0] frame_cnt_q, err_cnt_q;
  logic        ovf_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
      ovf_q       <= 1'b0;
    end else begin
      if (rd_en && m_tlast) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((state_q == StHdr) && !hdr_ok) err_cnt_q <= err_cnt_q + 16'd1;
      if (wr_en && full && !rd_en) ovf_q <= 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign ovf       = ovf_q;
`else
  assign frame_cnt = 16'd0;
  assign err_cnt   = 16'd0;
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_rece_fetch.sv
// Bench for rece_fetch: a buffer model answers send_start with random frames and a scoreboard
// predicts the payload stream and counters from the frame rules.
module tb_rece_fetch;

  localparam int RdLat  = 2;
  localparam int Depth  = 512;
  localparam int MaxLen = 256;
`ifdef RECE_FETCH_STAT_EN
  localparam bit Stat = 1'b1;
`else
  localparam bit Stat = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        rece_qune = 1'b0;
  logic        m_tready = 1'b0;
  logic [63:0] sfp_rd_data = 64'd0;
  logic        send_start, m_tvalid, m_tlast, ovf;
  logic [63:0] m_tdata;
  logic [15:0] frame_cnt, err_cnt;

  rece_fetch #(.RD_LAT(RdLat), .FIFO_DEPTH(Depth), .MAX_LEN(MaxLen)) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .rece_qune  (rece_qune),
    .send_start (send_start),
    .sfp_rd_data(sfp_rd_data),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .ovf        (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_until = 0;
  int          exp_frames = 0;
  int          exp_err = 0;
  int          pend_n[$];
  int          ss_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  logic [63:0] sched[int];

  // Buffer model: a send_start at cycle t puts the header on the bus in cycle t+RdLat.
  task automatic launch();
    int          n;
    logic [63:0] w;
    ss_q.push_back(cyc);
    if (pend_n.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_send_start: pulse at cycle %0d, required none", cyc);
      return;
    end
    n = pend_n.pop_front();
    w = {$urandom(), $urandom()};
    w[15:0] = n[15:0];
    sched[cyc + RdLat] = w;
    for (int k = 1; k <= n; k++) begin
      w = {$urandom(), $urandom()};
      sched[cyc + RdLat + k] = w;
      if (n <= MaxLen) exp_q.push_back({k == n, w});
    end
    if (n >= 1 && n <= MaxLen) exp_frames++;
    else exp_err++;
    busy_until = cyc + RdLat + n + 4;
  endtask

  initial begin
    forever begin
      @(posedge ap_clk);
      cyc++;
      #1;
      if (ap_rst_n && send_start) launch();
      if (sched.exists(cyc)) begin
        sfp_rd_data = sched[cyc];
        sched.delete(cyc);
      end else begin
        sfp_rd_data = {$urandom(), $urandom()};
      end
      rece_qune = (pend_n.size() != 0);
    end
  end

  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    end
  end

  task automatic next_cyc();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic drain(input int budget, output bit ok);
    int i = 0;
    while (i < budget && !(pend_n.size() == 0 && cyc > busy_until &&
                           got_q.size() >= exp_q.size())) begin
      next_cyc();
      i++;
    end
    repeat (3) next_cyc();
    ok = (i < budget);
  endtask

  task automatic wait_pulse(input int budget);
    int i = 0;
    while (ss_q.size() == 0 && i < budget) begin
      @(negedge ap_clk);
      i++;
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    n_cmp += 7;
    if (send_start !== 1'b0) begin n_bad++; $display("FAIL rst_send_start: got %b, required 0", send_start); end
    if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b, required 0", m_tvalid); end
    if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast: got %b, required 0", m_tlast); end
    if (m_tdata !== 64'd0) begin n_bad++; $display("FAIL rst_tdata: got %h, required 0", m_tdata); end
    if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
    if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_err_cnt: got %0d, required 0", err_cnt); end
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b, required 0", ovf); end
    next_cyc();
    ap_rst_n = 1'b1;
    repeat (4) next_cyc();
    n_cmp++;
    if (send_start !== 1'b0 || m_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_quiet: send_start %b tvalid %b, required 0 0", send_start, m_tvalid);
    end
  endtask

  task automatic test_single();
    int t;
    bit ok;
    ss_q.delete();
    m_tready = 1'b1;
    pend_n.push_back(4);
    wait_pulse(50);
    n_cmp++;
    if (ss_q.size() == 0) begin
      n_bad++;
      $display("FAIL single_pulse: got no send_start, required one");
      t = cyc;
    end else begin
      t = ss_q.pop_front();
    end
    n_cmp++;
    if (send_start !== 1'b1) begin n_bad++; $display("FAIL single_start_hi: got %b, required 1", send_start); end
    @(negedge ap_clk);
    n_cmp++;
    if (send_start !== 1'b0) begin n_bad++; $display("FAIL single_start_width: got %b, required 0", send_start); end
    while (cyc < t + RdLat + 1) @(negedge ap_clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL single_tvalid_early: got %b, required 0", m_tvalid); end
    @(negedge ap_clk);
    n_cmp++;
    if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL single_tvalid_on: got %b, required 1", m_tvalid); end
    if (exp_q.size() > 0) begin
      n_cmp++;
      if ({m_tlast, m_tdata} !== exp_q[0]) begin
        n_bad++;
        $display("FAIL single_first_word: got %h, required %h", {m_tlast, m_tdata}, exp_q[0]);
      end
    end
    drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_drain: got timeout, required idle"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL single_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL single_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
    n_cmp++;
    if (frame_cnt !== (Stat ? 16'(exp_frames) : 16'd0)) begin
      n_bad++;
      $display("FAIL single_frame_cnt: got %0d, required %0d", frame_cnt, Stat ? exp_frames : 0);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    ss_q.delete();
    m_tready = 1'b1;
    pend_n.push_back(0);
    pend_n.push_back(300);
    pend_n.push_back(2);
    drain(2000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL illegal_drain: got timeout, required idle"); end
    n_cmp++;
    if (ss_q.size() != 3) begin
      n_bad++;
      $display("FAIL illegal_pulses: got %0d, required 3", ss_q.size());
    end else begin
      n_cmp += 2;
      if (ss_q[1] - ss_q[0] != RdLat + 4) begin
        n_bad++;
        $display("FAIL illegal_gap_n0: got %0d, required %0d", ss_q[1] - ss_q[0], RdLat + 4);
      end
      if (ss_q[2] - ss_q[1] != RdLat + 304) begin
        n_bad++;
        $display("FAIL illegal_gap_drop: got %0d, required %0d", ss_q[2] - ss_q[1], RdLat + 304);
      end
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL illegal_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL illegal_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
    n_cmp += 2;
    if (err_cnt !== (Stat ? 16'(exp_err) : 16'd0)) begin
      n_bad++;
      $display("FAIL illegal_err_cnt: got %0d, required %0d", err_cnt, Stat ? exp_err : 0);
    end
    if (frame_cnt !== (Stat ? 16'(exp_frames) : 16'd0)) begin
      n_bad++;
      $display("FAIL illegal_frame_cnt: got %0d, required %0d", frame_cnt, Stat ? exp_frames : 0);
    end
  endtask

  task automatic test_backpressure();
    int          i = 0;
    bit          ok;
    bit          stable = 1'b1;
    logic [64:0] held;
    m_tready = 1'b0;
    pend_n.push_back(8);
    while (m_tvalid !== 1'b1 && i < 50) begin
      @(negedge ap_clk);
      i++;
    end
    held = {m_tlast, m_tdata};
    repeat (40) begin
      @(negedge ap_clk);
      if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== held) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL bp_stable: got changing head, required %h held", held); end
    next_cyc();
    m_tready = 1'b1;
    drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_drain: got timeout, required idle"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bp_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[j]) begin
        n_cmp++;
        if (got_q[j] !== exp_q[j]) begin
          n_bad++;
          $display("FAIL bp_word%0d: got %h, required %h", j, got_q[j], exp_q[j]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
    n_cmp++;
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL bp_ovf: got %b, required 0", ovf); end
  endtask

  task automatic test_random();
    int i = 0;
    int r;
    for (int f = 0; f < 14; f++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: pend_n.push_back(0);
        1: pend_n.push_back(MaxLen + 1);
        2: pend_n.push_back(MaxLen + $urandom_range(2, 40));
        3: pend_n.push_back(MaxLen);
        4: pend_n.push_back(1);
        default: pend_n.push_back($urandom_range(1, 16));
      endcase
    end
    while (i < 20000 && !(pend_n.size() == 0 && cyc > busy_until &&
                          got_q.size() >= exp_q.size())) begin
      next_cyc();
      m_tready = 1'($urandom_range(0, 1));
      i++;
    end
    m_tready = 1'b1;
    repeat (5) next_cyc();
    n_cmp++;
    if (i >= 20000) begin n_bad++; $display("FAIL rand_drain: got timeout, required idle"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[j]) begin
        n_cmp++;
        if (got_q[j] !== exp_q[j]) begin
          n_bad++;
          $display("FAIL rand_word%0d: got %h, required %h", j, got_q[j], exp_q[j]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
    n_cmp += 3;
    if (frame_cnt !== (Stat ? 16'(exp_frames) : 16'd0)) begin
      n_bad++;
      $display("FAIL rand_frame_cnt: got %0d, required %0d", frame_cnt, Stat ? exp_frames : 0);
    end
    if (err_cnt !== (Stat ? 16'(exp_err) : 16'd0)) begin
      n_bad++;
      $display("FAIL rand_err_cnt: got %0d, required %0d", err_cnt, Stat ? exp_err : 0);
    end
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL rand_ovf: got %b, required 0", ovf); end
  endtask

  task automatic test_full();
    int i = 0;
    int c0;
    bit ok;
    ss_q.delete();
    m_tready = 1'b0;
    repeat (3) pend_n.push_back(MaxLen);
    while ((ss_q.size() < 2 || cyc <= busy_until) && i < 3000) begin
      next_cyc();
      i++;
    end
    repeat (30) next_cyc();
    n_cmp++;
    if (ss_q.size() != 2) begin
      n_bad++;
      $display("FAIL full_blocked: got %0d pulses, required 2", ss_q.size());
    end
    ss_q.delete();
    next_cyc();
    c0 = cyc;
    m_tready = 1'b1;
    repeat (MaxLen) next_cyc();
    m_tready = 1'b0;
    wait_pulse(10);
    n_cmp++;
    if (ss_q.size() == 0) begin
      n_bad++;
      $display("FAIL full_release: got no pulse, required one at cycle %0d..%0d", c0 + MaxLen,
               c0 + MaxLen + 1);
    end else if (ss_q[0] < c0 + MaxLen || ss_q[0] > c0 + MaxLen + 1) begin
      n_bad++;
      $display("FAIL full_release: got pulse at cycle %0d, required %0d..%0d", ss_q[0],
               c0 + MaxLen, c0 + MaxLen + 1);
    end
    i = 0;
    while (cyc <= busy_until && i < 1000) begin
      next_cyc();
      i++;
    end
    m_tready = 1'b1;
    drain(2000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL full_drain: got timeout, required idle"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL full_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[j]) begin
        n_cmp++;
        if (got_q[j] !== exp_q[j]) begin
          n_bad++;
          $display("FAIL full_word%0d: got %h, required %h", j, got_q[j], exp_q[j]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
    n_cmp++;
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL full_ovf: got %b, required 0", ovf); end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    ss_q.delete();
    m_tready = 1'b1;
    pend_n.push_back(10);
    wait_pulse(50);
    t = (ss_q.size() != 0) ? ss_q.pop_front() : cyc;
    while (cyc < t + RdLat + 3) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    n_cmp += 7;
    if (send_start !== 1'b0) begin n_bad++; $display("FAIL mid_send_start: got %b, required 0", send_start); end
    if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_tvalid: got %b, required 0", m_tvalid); end
    if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL mid_tlast: got %b, required 0", m_tlast); end
    if (m_tdata !== 64'd0) begin n_bad++; $display("FAIL mid_tdata: got %h, required 0", m_tdata); end
    if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_frame_cnt: got %0d, required 0", frame_cnt); end
    if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_err_cnt: got %0d, required 0", err_cnt); end
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b, required 0", ovf); end
    // The buffer model aborts alongside the DUT so no residue reaches the next frame.
    sched.delete();
    exp_q.delete();
    got_q.delete();
    pend_n.delete();
    ss_q.delete();
    exp_frames = 0;
    exp_err = 0;
    busy_until = cyc;
    repeat (2) next_cyc();
    ap_rst_n = 1'b1;
    next_cyc();
    pend_n.push_back(3);
    drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_drain: got timeout, required idle"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL mid_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[j]) begin
        n_cmp++;
        if (got_q[j] !== exp_q[j]) begin
          n_bad++;
          $display("FAIL mid_word%0d: got %h, required %h", j, got_q[j], exp_q[j]);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== (Stat ? 16'd1 : 16'd0)) begin
      n_bad++;
      $display("FAIL mid_frame_cnt_after: got %0d, required %0d", frame_cnt, Stat ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_backpressure();
    test_random();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
